// File: rtl/calc_pkg.sv
// Shared opcodes, FSM encoding and constants for the calc_pipe arithmetic engine.
package calc_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_REM = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  // Sliced down to the operand width; supports WIDTH up to 128.
  localparam logic [127:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/calc_fifo.sv
// Synchronous result FIFO; pointers carry an extra wrap bit to tell full from empty.
module calc_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 34
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DW-1:0]                push_data,
  input  logic                         pop,
  output logic [DW-1:0]                pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level   = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/calc_pipe.sv
// Back-pressured calculator: 8-op ALU, iterative restoring divider, in-order result FIFO.
module calc_pipe
  import calc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2:0]                  in_op,
  input  logic [WIDTH-1:0]            in_a,
  input  logic [WIDTH-1:0]            in_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_ovf,
  output logic                        out_err,
  output logic [$clog2(DEPTH+1)-1:0]  level,
  output logic                        busy
);

  localparam int CW = $clog2(WIDTH);

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt;
  logic                   accept;
  logic [2:0]             op_p0;
  logic [WIDTH-1:0]       a_p0, b_p0;
  logic [WIDTH:0]         rem_p1;
  logic [WIDTH-1:0]       quo_p1;
  logic [WIDTH+1:0]       shifted;
  logic [WIDTH+1:0]       trial;
  logic                   ge;
  logic [WIDTH:0]         rem_nxt;
  logic [WIDTH-1:0]       quo_nxt;
  logic                   push;
  logic [WIDTH+1:0]       push_data;
  logic [WIDTH+1:0]       head;
  logic                   fifo_full, fifo_empty;

  function automatic logic [WIDTH+1:0] alu_exec(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   d;
    logic               ovf, err;
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    d    = '0;
    ovf  = 1'b0;
    err  = 1'b0;
    case (op)
      OP_ADD: begin d = sum[WIDTH-1:0];   ovf = sum[WIDTH];            end
      OP_SUB: begin d = diff[WIDTH-1:0];  ovf = diff[WIDTH];           end
      OP_MUL: begin d = prod[WIDTH-1:0];  ovf = |prod[2*WIDTH-1:WIDTH]; end
      // Only divide-by-zero reaches EXEC with a divide opcode.
      OP_DIV: begin d = DIV_ZERO_Q[WIDTH-1:0]; err = 1'b1; end
      OP_REM: begin d = a;                     err = 1'b1; end
      OP_AND: d = a & b;
      OP_OR:  d = a | b;
      default: d = a ^ b;
    endcase
    return {d, ovf, err};
  endfunction

  assign in_ready = !rst && (state == ST_IDLE) && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != ST_IDLE);

  // Restoring divide step: shift in the next dividend bit, subtract if it fits.
  assign shifted = {rem_p1, quo_p1[WIDTH-1]};
  assign trial   = shifted - {2'b00, b_p0};
  assign ge      = (shifted >= {2'b00, b_p0});
  assign rem_nxt = ge ? trial[WIDTH:0] : shifted[WIDTH:0];
  assign quo_nxt = {quo_p1[WIDTH-2:0], ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)                         cnt <= CW'(WIDTH-1);
      else if (state == ST_DIV && cnt != '0) cnt <= cnt - CW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_data = '0;
    case (state)
      ST_IDLE: begin
        if (accept)
          state_nxt = ((in_op == OP_DIV || in_op == OP_REM) && in_b != '0) ? ST_DIV : ST_EXEC;
      end
      ST_EXEC: begin
        push      = 1'b1;
        push_data = alu_exec(op_p0, a_p0, b_p0);
        state_nxt = ST_IDLE;
      end
      ST_DIV: begin
        if (cnt == '0) begin
          push      = 1'b1;
          push_data = {(op_p0 == OP_REM) ? rem_nxt[WIDTH-1:0] : quo_nxt, 2'b00};
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // p0: operands latched at accept; p1: divider working registers
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0  <= in_op;
      a_p0   <= in_a;
      b_p0   <= in_b;
      rem_p1 <= '0;
      quo_p1 <= in_a;
    end else if (state == ST_DIV) begin
      rem_p1 <= rem_nxt;
      quo_p1 <= quo_nxt;
    end
  end

  calc_fifo #(.DEPTH(DEPTH), .DW(WIDTH+2)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (out_ready),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  // Head is masked while empty so the unreset storage never shows through.
  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? head[WIDTH+1:2] : '0;
  assign out_ovf   = out_valid && head[1];
  assign out_err   = out_valid && head[0];

endmodule
